pdp_rdma_rd_req_gen: RTL

//  PDP RDMA read-request initiator: walks a 2-D surface (lines x atoms) from one command and

---
 rtl/pdp_rdma_rd_req_gen_if.sv | 41 ++++
 rtl/pdp_rdma_rd_req_gen.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pdp_rdma_rd_req_gen_if.sv
// Command and read-request channels of the PDP RDMA read-request generator.
// master: the request generator (consumes commands, issues read requests).
// slave : the command source / memory-interface side.
interface pdp_rdma_rd_req_gen_if #(
  parameter int ADDR_W = 64
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [ADDR_W-1:0]   cmd_base_addr;
  logic [12:0]         cmd_line_size;
  logic [12:0]         cmd_line_num;
  logic [ADDR_W-1:0]   cmd_line_stride;

  logic                pdp2mcif_rd_req_valid;
  logic                pdp2mcif_rd_req_ready;
  logic [ADDR_W+14:0]  pdp2mcif_rd_req_pd;

  modport master (
    input  cmd_valid,
    output cmd_ready,
    input  cmd_base_addr,
    input  cmd_line_size,
    input  cmd_line_num,
    input  cmd_line_stride,
    output pdp2mcif_rd_req_valid,
    input  pdp2mcif_rd_req_ready,
    output pdp2mcif_rd_req_pd
  );

  modport slave (
    output cmd_valid,
    input  cmd_ready,
    output cmd_base_addr,
    output cmd_line_size,
    output cmd_line_num,
    output cmd_line_stride,
    input  pdp2mcif_rd_req_valid,
    output pdp2mcif_rd_req_ready,
    input  pdp2mcif_rd_req_pd
  );
endinterface

// File: rtl/pdp_rdma_rd_req_gen.sv
// PDP RDMA read-request generator: walks a lines x atoms surface, splits each
// line into bursts of at most MAX_BURST atoms and issues them on the
// pdp2mcif_rd_req channel, limited by credits from the response latency FIFO.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a command; cmd_ready high
// ST_ISSUE | generating bursts; ends when the last burst is accepted
// ST_DRAIN | all bursts issued; waiting for outstanding atoms to return
module pdp_rdma_rd_req_gen #(
  parameter int ADDR_W    = 64,
  parameter int MAX_BURST = 8,
  parameter int LAT_DEPTH = 128
) (
  input  logic                          nvdla_core_clk,
  input  logic                          nvdla_core_rst,
  pdp_rdma_rd_req_gen_if.master         bus,
  input  logic                          rsp_atom_ret,
  output logic                          busy,
  output logic                          op_done
);

  localparam int OW = $clog2(LAT_DEPTH + 1);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam int PW = ADDR_W + 15;
  localparam logic [ADDR_W-1:0] ATOM_MASK = ~ADDR_W'(31);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] line_addr_q, line_addr_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [12:0]       line_size_q, line_size_d;
  logic [12:0]       line_num_q, line_num_d;
  logic [12:0]       line_cnt_q, line_cnt_d;
  logic [12:0]       atom_idx_q, atom_idx_d;
  logic              all_loaded_q, all_loaded_d;
  logic              valid_q, valid_d;
  logic [PW-1:0]     pd_q, pd_d;
  logic [CW-1:0]     cur_chunk_q, cur_chunk_d;
  logic [OW-1:0]     outstanding_q, outstanding_d;

  logic [13:0]       rem;
  logic              line_end;
  logic [CW-1:0]     chunk;
  logic              accept;
  logic              load;
  logic [31:0]       need;

  // Size of the next burst and whether the credit pool can take it. The
  // request in flight is charged up front so back-to-back loads stay safe.
  always_comb begin
    rem      = {1'b0, line_size_q} - {1'b0, atom_idx_q} + 14'd1;
    line_end = (rem <= 14'(MAX_BURST));
    chunk    = line_end ? rem[CW-1:0] : CW'(MAX_BURST);
    accept   = valid_q && bus.pdp2mcif_rd_req_ready;
    need     = 32'(outstanding_q) + (valid_q ? 32'(cur_chunk_q) : 32'd0) + 32'(chunk);
    load     = (state_q == ST_ISSUE) && !all_loaded_q &&
               (!valid_q || bus.pdp2mcif_rd_req_ready) &&
               (need <= 32'(LAT_DEPTH));
  end

  // Next state, command latch, surface walk and request register.
  always_comb begin
    state_d      = state_q;
    line_addr_d  = line_addr_q;
    stride_d     = stride_q;
    line_size_d  = line_size_q;
    line_num_d   = line_num_q;
    line_cnt_d   = line_cnt_q;
    atom_idx_d   = atom_idx_q;
    all_loaded_d = all_loaded_q;
    valid_d      = valid_q;
    pd_d         = pd_q;
    cur_chunk_d  = cur_chunk_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          state_d      = ST_ISSUE;
          line_addr_d  = bus.cmd_base_addr & ATOM_MASK;
          stride_d     = bus.cmd_line_stride & ATOM_MASK;
          line_size_d  = bus.cmd_line_size;
          line_num_d   = bus.cmd_line_num;
          line_cnt_d   = '0;
          atom_idx_d   = '0;
          all_loaded_d = 1'b0;
        end
      end
      ST_ISSUE: begin
        if (accept && all_loaded_q) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (outstanding_q == '0) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      valid_d = 1'b0;
    end

    if (load) begin
      valid_d     = 1'b1;
      cur_chunk_d = chunk;
      pd_d        = {15'(chunk) - 15'd1, line_addr_q + (ADDR_W'(atom_idx_q) << 5)};
      if (line_end) begin
        atom_idx_d  = '0;
        line_addr_d = line_addr_q + stride_q;
        if (line_cnt_q == line_num_q) begin
          all_loaded_d = 1'b1;
        end else begin
          line_cnt_d = line_cnt_q + 13'd1;
        end
      end else begin
        atom_idx_d = atom_idx_q + 13'(chunk);
      end
    end
  end

  // Credit counter: charged on accept, refunded one atom per return; a
  // return with nothing outstanding is dropped.
  always_comb begin
    outstanding_d = outstanding_q;
    if (accept) begin
      outstanding_d = outstanding_d + OW'(cur_chunk_q);
    end
    if (rsp_atom_ret && (outstanding_q != '0)) begin
      outstanding_d = outstanding_d - OW'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state_q       <= ST_IDLE;
      line_addr_q   <= '0;
      stride_q      <= '0;
      line_size_q   <= '0;
      line_num_q    <= '0;
      line_cnt_q    <= '0;
      atom_idx_q    <= '0;
      all_loaded_q  <= 1'b0;
      valid_q       <= 1'b0;
      pd_q          <= '0;
      cur_chunk_q   <= '0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      line_addr_q   <= line_addr_d;
      stride_q      <= stride_d;
      line_size_q   <= line_size_d;
      line_num_q    <= line_num_d;
      line_cnt_q    <= line_cnt_d;
      atom_idx_q    <= atom_idx_d;
      all_loaded_q  <= all_loaded_d;
      valid_q       <= valid_d;
      pd_q          <= pd_d;
      cur_chunk_q   <= cur_chunk_d;
      outstanding_q <= outstanding_d;
    end
  end

  assign bus.cmd_ready             = (state_q == ST_IDLE);
  assign bus.pdp2mcif_rd_req_valid = valid_q;
  assign bus.pdp2mcif_rd_req_pd    = pd_q;
  assign busy                      = (state_q != ST_IDLE);
  assign op_done                   = (state_q == ST_DRAIN) && (outstanding_q == '0);

  ret_underflow_a: assert property (@(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
                                    !(rsp_atom_ret && (outstanding_q == '0)))
    else $warning("credit return with no atoms outstanding");

endmodule
